// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART byte stream, transmitter and register bus signals of the command controller
interface uart_cmd_ctrl_if #(
  parameter int AW = 8
);
  logic [7:0]    rx_data;
  logic          po_flag;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_wr;
  logic          reg_rd;
  logic [7:0]    reg_rdata;
  logic          frame_err;

  modport master (
    input  rx_data, po_flag, tx_busy, reg_rdata,
    output tx_data, tx_start, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err
  );

  modport slave (
    output rx_data, po_flag, tx_busy, reg_rdata,
    input  tx_data, tx_start, reg_addr, reg_wdata, reg_wr, reg_rd, frame_err
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - parses UART command frames, runs register reads/writes and sequences responses
module uart_cmd_ctrl #(
  parameter int       AW          = 8,
  parameter int       TIMEOUT_MAX = 62499,
  parameter bit [7:0] HDR         = 8'h55
) (
  input  logic             sclk,
  input  logic             rst_n,
  uart_cmd_ctrl_if.master  bus
);
  localparam int TW = $clog2(TIMEOUT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC,
    S_RD_WAIT, S_TX_ACK, S_TX_RD, S_TX_NAK, S_TX_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_is_rd;
  logic          r_rd_pend;
  logic          r_armed;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_csum;
  logic [7:0]    r_rdata;
  logic [TW-1:0] r_tout;
  logic          r_frame_err;
  logic          r_tx_start;
  logic [7:0]    r_tx_data;
  logic          w_err;
  logic          w_tx_go;
  logic [7:0]    w_tx_byte;
  logic          w_timed;
  logic          w_timeout;

  assign w_timed   = (r_state == S_CMD) || (r_state == S_ADDR) ||
                     (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout = w_timed && (r_tout == TW'(TIMEOUT_MAX));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // An incoming byte always takes priority over the timeout terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_tx_go     = 1'b0;
    w_tx_byte   = r_tx_data;
    case (r_state)
      S_IDLE: begin
        if (bus.po_flag && bus.rx_data == HDR) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (bus.po_flag) begin
          if (bus.rx_data == 8'h01 || bus.rx_data == 8'h02) begin
            w_state_nxt = S_ADDR;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        if (bus.po_flag) begin
          w_state_nxt = r_is_rd ? S_CSUM : S_DATA;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        if (bus.po_flag) begin
          w_state_nxt = S_CSUM;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CSUM: begin
        if (bus.po_flag) begin
          if (bus.rx_data == r_csum) begin
            w_state_nxt = S_EXEC;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_TX_NAK;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC:    w_state_nxt = r_is_rd ? S_RD_WAIT : S_TX_ACK;
      S_RD_WAIT: w_state_nxt = S_TX_ACK;
      S_TX_ACK, S_TX_RD, S_TX_NAK: begin
        if (!bus.tx_busy) begin
          w_tx_go     = 1'b1;
          w_state_nxt = S_TX_WAIT;
          if (r_state == S_TX_ACK)     w_tx_byte = 8'hAA;
          else if (r_state == S_TX_RD) w_tx_byte = r_rdata;
          else                         w_tx_byte = 8'hEE;
        end
      end
      S_TX_WAIT: begin
        if (r_armed && !bus.tx_busy) w_state_nxt = r_rd_pend ? S_TX_RD : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_rd     <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_armed     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 8'h00;
      r_csum      <= 8'h00;
      r_rdata     <= 8'h00;
      r_tout      <= '0;
      r_frame_err <= 1'b0;
      r_tx_start  <= 1'b0;
      r_tx_data   <= 8'h00;
    end else begin
      r_frame_err <= w_err;
      r_tx_start  <= w_tx_go;
      if (w_tx_go) r_tx_data <= w_tx_byte;
      // Ignore tx_busy on the first TX_WAIT cycle: the transmitter raises it one cycle late.
      r_armed <= (r_state == S_TX_WAIT);
      if (w_timed && !bus.po_flag && w_state_nxt == r_state) r_tout <= r_tout + TW'(1);
      else                                                   r_tout <= '0;
      case (r_state)
        S_CMD: begin
          if (bus.po_flag && (bus.rx_data == 8'h01 || bus.rx_data == 8'h02)) begin
            r_is_rd <= (bus.rx_data == 8'h02);
            r_csum  <= bus.rx_data;
          end
        end
        S_ADDR: begin
          if (bus.po_flag) begin
            r_addr <= bus.rx_data[AW-1:0];
            r_csum <= r_csum + bus.rx_data;
          end
        end
        S_DATA: begin
          if (bus.po_flag) begin
            r_wdata <= bus.rx_data;
            r_csum  <= r_csum + bus.rx_data;
          end
        end
        S_RD_WAIT: r_rdata <= bus.reg_rdata;
        S_TX_ACK:  if (w_tx_go) r_rd_pend <= r_is_rd;
        S_TX_RD, S_TX_NAK: if (w_tx_go) r_rd_pend <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.reg_wr    = (r_state == S_EXEC) && !r_is_rd;
  assign bus.reg_rd    = (r_state == S_EXEC) && r_is_rd;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.frame_err = r_frame_err;
  assign bus.tx_start  = r_tx_start;
  assign bus.tx_data   = r_tx_data;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  localparam int TO = 100;

  logic sclk;
  logic rst_n;
  uart_cmd_ctrl_if #(.AW(8)) bus ();

  uart_cmd_ctrl #(.AW(8), .TIMEOUT_MAX(TO), .HDR(8'h55)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  int n_cmp;
  int n_bad;
  int wr_cycles, rd_cycles, err_cycles, busy_viol;
  logic [7:0] wr_addr, wr_data, rd_addr;
  logic [7:0] tx_log[$];
  int busy_cnt;

  // Transmitter model: busy rises the cycle after tx_start and lasts 10 cycles.
  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.tx_busy <= 1'b0;
      busy_cnt    <= 0;
    end else if (bus.tx_start) begin
      bus.tx_busy <= 1'b1;
      busy_cnt    <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) bus.tx_busy <= 1'b0;
    end
  end

  // Register model: addr 20 reads 5A, anything else reads the inverted address.
  always @(posedge sclk) begin
    if (bus.reg_rd) bus.reg_rdata <= (bus.reg_addr == 8'h20) ? 8'h5A : ~bus.reg_addr;
  end

  always @(negedge sclk) begin
    if (bus.reg_wr) begin
      wr_cycles++;
      wr_addr = bus.reg_addr;
      wr_data = bus.reg_wdata;
    end
    if (bus.reg_rd) begin
      rd_cycles++;
      rd_addr = bus.reg_addr;
    end
    if (bus.frame_err) err_cycles++;
    if (bus.tx_start) begin
      tx_log.push_back(bus.tx_data);
      if (bus.tx_busy) busy_viol++;
    end
  end

  task automatic clear_logs();
    wr_cycles = 0; rd_cycles = 0; err_cycles = 0; busy_viol = 0;
    wr_addr = 8'h00; wr_data = 8'h00; rd_addr = 8'h00;
    tx_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge sclk);
    bus.po_flag = 1'b1;
    bus.rx_data = b;
    @(negedge sclk);
    bus.po_flag = 1'b0;
    repeat (2) @(negedge sclk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sclk);
  endtask

  function automatic logic [7:0] tx_at(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 8'hxx;
  endfunction

  task automatic test_reset();
    n_cmp++; if (bus.tx_start !== 1'b0)  begin n_bad++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
    n_cmp++; if (bus.tx_data !== 8'h00)  begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    n_cmp++; if (bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0) begin n_bad++; $display("FAIL reset_strobes: got wr=%b rd=%b want 0 0", bus.reg_wr, bus.reg_rd); end
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
    n_cmp++; if (bus.reg_addr !== 8'h00 || bus.reg_wdata !== 8'h00) begin n_bad++; $display("FAIL reset_latches: got addr=%h wdata=%h want 00 00", bus.reg_addr, bus.reg_wdata); end
  endtask

  task automatic test_write();
    clear_logs();
    send_byte(8'h00); send_byte(8'hFF);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h4D);
    idle(60);
    n_cmp++; if (wr_cycles !== 1) begin n_bad++; $display("FAIL write_strobe_cycles: got %0d want 1", wr_cycles); end
    n_cmp++; if (wr_addr !== 8'h10 || wr_data !== 8'h3C) begin n_bad++; $display("FAIL write_addr_data: got %h/%h want 10/3c", wr_addr, wr_data); end
    n_cmp++; if (tx_log.size() !== 1 || tx_at(0) !== 8'hAA) begin n_bad++; $display("FAIL write_resp: got n=%0d b0=%h want n=1 b0=aa", tx_log.size(), tx_at(0)); end
    n_cmp++; if (err_cycles !== 0 || rd_cycles !== 0) begin n_bad++; $display("FAIL write_side: got err=%0d rd=%0d want 0 0", err_cycles, rd_cycles); end
    n_cmp++; if (bus.reg_addr !== 8'h10 || bus.reg_wdata !== 8'h3C) begin n_bad++; $display("FAIL write_hold: got %h/%h want 10/3c", bus.reg_addr, bus.reg_wdata); end
  endtask

  task automatic test_read();
    clear_logs();
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
    idle(60);
    n_cmp++; if (rd_cycles !== 1 || rd_addr !== 8'h20) begin n_bad++; $display("FAIL read_strobe: got n=%0d addr=%h want 1 20", rd_cycles, rd_addr); end
    n_cmp++; if (tx_log.size() !== 2 || tx_at(0) !== 8'hAA || tx_at(1) !== 8'h5A) begin n_bad++; $display("FAIL read_resp: got n=%0d %h %h want 2 aa 5a", tx_log.size(), tx_at(0), tx_at(1)); end
    n_cmp++; if (busy_viol !== 0 || wr_cycles !== 0 || err_cycles !== 0) begin n_bad++; $display("FAIL read_side: got viol=%0d wr=%0d err=%0d want 0 0 0", busy_viol, wr_cycles, err_cycles); end
  endtask

  task automatic test_bad_csum();
    clear_logs();
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h00);
    idle(60);
    n_cmp++; if (err_cycles !== 1) begin n_bad++; $display("FAIL csum_err: got %0d want 1", err_cycles); end
    n_cmp++; if (wr_cycles !== 0) begin n_bad++; $display("FAIL csum_no_wr: got %0d want 0", wr_cycles); end
    n_cmp++; if (tx_log.size() !== 1 || tx_at(0) !== 8'hEE) begin n_bad++; $display("FAIL csum_resp: got n=%0d b0=%h want 1 ee", tx_log.size(), tx_at(0)); end
  endtask

  task automatic test_unknown_cmd();
    clear_logs();
    send_byte(8'h55); send_byte(8'h07);
    idle(30);
    n_cmp++; if (err_cycles !== 1 || tx_log.size() !== 0) begin n_bad++; $display("FAIL unk_cmd: got err=%0d tx=%0d want 1 0", err_cycles, tx_log.size()); end
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
    idle(60);
    n_cmp++; if (rd_cycles !== 1 || tx_log.size() !== 2 || tx_at(1) !== 8'h5A) begin n_bad++; $display("FAIL unk_recover: got rd=%0d tx=%0d b1=%h want 1 2 5a", rd_cycles, tx_log.size(), tx_at(1)); end
  endtask

  task automatic test_timeout();
    clear_logs();
    send_byte(8'h55); send_byte(8'h01);
    idle(TO + 10);
    n_cmp++; if (err_cycles !== 1) begin n_bad++; $display("FAIL timeout_err: got %0d want 1", err_cycles); end
    send_byte(8'h10); send_byte(8'h3C); send_byte(8'h4D);
    idle(60);
    n_cmp++; if (tx_log.size() !== 0 || wr_cycles !== 0 || err_cycles !== 1) begin n_bad++; $display("FAIL timeout_discard: got tx=%0d wr=%0d err=%0d want 0 0 1", tx_log.size(), wr_cycles, err_cycles); end
  endtask

  // The second byte lands exactly on the terminal count cycle and must still be accepted.
  task automatic test_timeout_edge();
    clear_logs();
    @(negedge sclk);
    bus.po_flag = 1'b1;
    bus.rx_data = 8'h55;
    @(negedge sclk);
    bus.po_flag = 1'b0;
    repeat (TO) @(negedge sclk);
    bus.po_flag = 1'b1;
    bus.rx_data = 8'h02;
    @(negedge sclk);
    bus.po_flag = 1'b0;
    send_byte(8'h20); send_byte(8'h22);
    idle(60);
    n_cmp++; if (err_cycles !== 0 || tx_log.size() !== 2 || tx_at(1) !== 8'h5A) begin n_bad++; $display("FAIL timeout_edge: got err=%0d tx=%0d b1=%h want 0 2 5a", err_cycles, tx_log.size(), tx_at(1)); end
  endtask

  task automatic test_drop_in_tx_wait();
    int waited;
    clear_logs();
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h4D);
    waited = 0;
    while (!bus.tx_start && waited < 100) begin @(negedge sclk); waited++; end
    n_cmp++; if (bus.tx_start !== 1'b1) begin n_bad++; $display("FAIL drop_wait_start: got %b want 1", bus.tx_start); end
    idle(1);
    send_byte(8'h55);
    idle(40);
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
    idle(60);
    n_cmp++; if (tx_log.size() !== 1 || rd_cycles !== 0) begin n_bad++; $display("FAIL drop_byte: got tx=%0d rd=%0d want 1 0", tx_log.size(), rd_cycles); end
  endtask

  task automatic test_reset_mid();
    int waited;
    clear_logs();
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h33); send_byte(8'h35);
    waited = 0;
    while (!bus.tx_start && waited < 100) begin @(negedge sclk); waited++; end
    n_cmp++; if (bus.tx_start !== 1'b1) begin n_bad++; $display("FAIL rstmid_wait_start: got %b want 1", bus.tx_start); end
    idle(2);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.tx_start !== 1'b0 || bus.reg_wr !== 1'b0 || bus.reg_rd !== 1'b0 || bus.tx_data !== 8'h00) begin n_bad++; $display("FAIL rstmid_outputs: got start=%b wr=%b rd=%b txd=%h want 0 0 0 00", bus.tx_start, bus.reg_wr, bus.reg_rd, bus.tx_data); end
    idle(3);
    rst_n = 1'b1;
    idle(20);
    n_cmp++; if (tx_log.size() !== 1) begin n_bad++; $display("FAIL rstmid_abandon: got tx=%0d want 1", tx_log.size()); end
    clear_logs();
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
    idle(60);
    n_cmp++; if (tx_log.size() !== 2 || tx_at(0) !== 8'hAA || tx_at(1) !== 8'h5A) begin n_bad++; $display("FAIL rstmid_recover: got n=%0d %h %h want 2 aa 5a", tx_log.size(), tx_at(0), tx_at(1)); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clear_logs();
    rst_n       = 1'b0;
    bus.po_flag = 1'b0;
    bus.rx_data = 8'h00;
    bus.reg_rdata = 8'h00;
    idle(4);
    rst_n = 1'b1;
    idle(2);
    test_reset();
    test_write();
    test_read();
    test_bad_csum();
    test_unknown_cmd();
    test_timeout();
    test_timeout_edge();
    test_drop_in_tx_wait();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
